// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, FSM state type
// and small op-class helpers used by both the unit and the E-stage decoder.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_W = 32;

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Operations that open a busy window when started.
    function automatic logic is_md_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_md_div(op);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> md unit bundle. master = E stage (issues ops), slave = md unit.
interface md_unit_if;
    import md_unit_pkg::*;

    // start is a one-cycle pulse with no ready: the initiator must only raise it
    // when md_stall was low, since a start seen while busy is dropped.
    logic            start;
    logic [3:0]      md_op;
    logic [MD_W-1:0] src_a;
    logic [MD_W-1:0] src_b;
    logic            busy;
    logic            md_stall;
    logic [MD_W-1:0] hi;
    logic [MD_W-1:0] lo;
    logic [MD_W-1:0] md_out;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, md_stall, hi, lo, md_out
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, md_stall, hi, lo, md_out
    );

endinterface

// File: rtl/md_unit_calc.sv
// Combinational 32x32 multiply/divide datapath producing a {hi,lo} pair.
// Signed divide works on magnitudes so the 0x80000000 / -1 case wraps naturally.
module md_unit_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        div_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    always_comb begin
        result      = '0;
        div_by_zero = is_md_div(op) && (b == 32'd0);
        div_signed  = (op == MD_DIV);

        mag_a  = (div_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b  = (div_signed && b[31]) ? (~b + 32'd1) : b;
        // Zero divisor result is discarded at commit; avoid a divide by zero here.
        safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quot_u = mag_a / safe_b;
        rem_u  = mag_a % safe_b;
        quot   = (div_signed && (a[31] ^ b[31])) ? (~quot_u + 32'd1) : quot_u;
        rem    = (div_signed && a[31]) ? (~rem_u + 32'd1) : rem_u;

        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};

        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem, quot};
            MD_DIVU:  result = {rem, quot};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: latches a result on start, holds busy for a
// fixed number of cycles, then commits it into HI/LO. MFHI/MFLO read combinationally.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus,
    output md_state_e  dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [63:0]        pending, pending_nxt;
    logic               pend_dbz, pend_dbz_nxt;
    logic [31:0]        hi_q, hi_nxt;
    logic [31:0]        lo_q, lo_nxt;

    logic [63:0]        calc_result;
    logic               calc_dbz;

    md_unit_calc u_calc (
        .op          (bus.md_op),
        .a           (bus.src_a),
        .b           (bus.src_b),
        .result      (calc_result),
        .div_by_zero (calc_dbz)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            pending  <= '0;
            pend_dbz <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            pending  <= pending_nxt;
            pend_dbz <= pend_dbz_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        pending_nxt  = pending;
        pend_dbz_nxt = pend_dbz;
        hi_nxt       = hi_q;
        lo_nxt       = lo_q;

        case (state)
            ST_IDLE: begin
                if (bus.start && is_md_arith(bus.md_op)) begin
                    pending_nxt  = calc_result;
                    pend_dbz_nxt = calc_dbz;
                    count_nxt    = is_md_div(bus.md_op) ? CNT_W'(DIV_CYCLES)
                                                        : CNT_W'(MULT_CYCLES);
                    state_nxt    = ST_BUSY;
                end else if (!bus.start && bus.md_op == MD_MTHI) begin
                    hi_nxt = bus.src_a;
                end else if (!bus.start && bus.md_op == MD_MTLO) begin
                    lo_nxt = bus.src_a;
                end
            end
            ST_BUSY: begin
                // Starts and MTHI/MTLO arriving here are dropped; md_stall keeps them out.
                if (count == CNT_W'(1)) begin
                    if (!pend_dbz) begin
                        hi_nxt = pending[63:32];
                        lo_nxt = pending[31:0];
                    end
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state == ST_BUSY);
    assign bus.md_stall = bus.start | bus.busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_out   = (bus.md_op == MD_MFHI) ? hi_q :
                          (bus.md_op == MD_MFLO) ? lo_q : 32'h0;
    assign dbg_state    = state;

    start_while_busy: assert property (@(posedge clk) disable iff (!reset)
        !(bus.start && state == ST_BUSY));

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-timed reference model checked every cycle,
// plus literal expectations for the hand-worked vectors.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic      clk;
    logic      reset;
    md_state_e dbg_state;
    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The pending result commits at an absolute cycle number; busy is simply
    // "a commit is outstanding".
    int          cyc = 0;
    bit          model_ok = 0;
    bit          m_pend = 0;
    bit          m_dbz = 0;
    int          m_due = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic void model_compute(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic [63:0] res,
                                          output bit dbz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = '0;
        dbz = 0;
        if (op == MD_MULT) res = 64'(sa * sb);
        else if (op == MD_MULTU) res = ua * ub;
        else if (b == 32'd0) dbz = 1;
        else if (op == MD_DIV) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[31:0], sq[31:0]};
        end else begin
            res = {32'(ua % ub), 32'(ua / ub)};
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        model_ok = 1;
        if (!reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = 0;
        end else if (m_pend) begin
            if (cyc == m_due) begin
                if (!m_dbz) {m_hi, m_lo} = m_res;
                m_pend = 0;
            end
        end else if (bus.start && (bus.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
            model_compute(bus.md_op, bus.src_a, bus.src_b, m_res, m_dbz);
            m_pend = 1;
            m_due  = cyc + ((bus.md_op inside {MD_DIV, MD_DIVU}) ? DIV_N : MULT_N);
        end else if (!bus.start && bus.md_op == MD_MTHI) begin
            m_hi = bus.src_a;
        end else if (!bus.start && bus.md_op == MD_MTLO) begin
            m_lo = bus.src_a;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("busy", bus.busy, m_pend);
            check("md_stall", bus.md_stall, bus.start | m_pend);
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
            check("md_out", bus.md_out,
                  (bus.md_op == MD_MFHI) ? m_hi : (bus.md_op == MD_MFLO) ? m_lo : 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_len);
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        #1 check("md_stall_in_start_cycle", bus.md_stall, 1);
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        busy_len = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy) busy_len++;
            else break;
        end
    endtask

    task automatic run_vec(input string name, input md_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_len,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int len;
        do_op(op, a, b, len);
        check({name, "_busy_len"}, len, exp_len);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    task automatic write_mt(input md_op_e op, input logic [31:0] a);
        @(posedge clk); #2;
        bus.md_op = op;
        bus.src_a = a;
        @(posedge clk); #2;
        bus.md_op = MD_NONE;
    endtask

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t extra[6] = '{
        '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF},
        '{MD_MULT,  32'h8000_0000, 32'hFFFF_FFFF},
        '{MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0},
        '{MD_DIV,   32'd7,         32'hFFFF_FFFE},
        '{MD_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9},
        '{MD_DIVU,  32'hFFFF_FFFF, 32'd10}
    };

    // ---------------- main sequence ----------------
    initial begin
        int len;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        bus.src_a = '0;
        bus.src_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        check("reset_busy", bus.busy, 1'b0);
        @(posedge clk); #2 reset = 1'b1;

        run_vec("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_vec("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
        run_vec("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_vec("divu",      MD_DIVU,  32'd7,         32'd2, DIV_N,  32'h0000_0001, 32'h0000_0003);

        write_mt(MD_MTHI, 32'h11);
        write_mt(MD_MTLO, 32'h22);
        run_vec("div_by_zero", MD_DIV, 32'd5, 32'd0, DIV_N, 32'h11, 32'h22);
        run_vec("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

        // MTHI then MFHI on the following cycle.
        @(posedge clk); #2;
        bus.md_op = MD_MTHI;
        bus.src_a = 32'hDEAD;
        @(posedge clk); #2;
        bus.md_op = MD_MFHI;
        #1 check("mfhi_after_mthi", bus.md_out, 32'hDEAD);
        @(posedge clk); #2 bus.md_op = MD_NONE;

        // MTLO while a MULT is in flight is dropped; the MULT result still lands.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.md_op = MD_MTLO; bus.src_a = 32'hBEEF;
        repeat (2) @(posedge clk);
        #2 bus.md_op = MD_NONE;
        @(negedge clk);
        check("mtlo_busy_lo_kept", bus.lo, 32'h8000_0000);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("mtlo_busy_commit_hi", bus.hi, 32'h0);
        check("mtlo_busy_commit_lo", bus.lo, 32'd12);

        foreach (extra[i]) begin
            do_op(extra[i].op, extra[i].a, extra[i].b, len);
            check("extra_busy_len", len,
                  (extra[i].op inside {MD_DIV, MD_DIVU}) ? DIV_N : MULT_N);
        end

        // Reset on the third busy cycle of a DIV abandons it; MFLO shows stale lo meanwhile.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.md_op = MD_MFLO;
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        bus.md_op = MD_NONE;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        repeat (15) @(negedge clk);
        check("abort_no_commit_hi", bus.hi, 32'h0);
        check("abort_no_commit_lo", bus.lo, 32'h0);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
